// File: rtl/if_id_pipe_if.sv
// -----------------------------------------------------------------------------
// if_id_pipe_if
//   Bundles the fetch-side and decode-side handshakes of the IF/ID stage,
//   plus the flush strobe and the occupancy status.
//   master : driven by the fetch/decode environment (flush, in_*, out_ready)
//   slave  : the pipeline stage itself (in_ready, out_*, occupancy)
// -----------------------------------------------------------------------------
interface if_id_pipe_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_npc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_npc;
    logic [1:0]         occupancy;

    modport master (
        output flush, in_valid, in_instr, in_npc, out_ready,
        input  in_ready, out_valid, out_instr, out_npc, occupancy
    );

    modport slave (
        input  flush, in_valid, in_instr, in_npc, out_ready,
        output in_ready, out_valid, out_instr, out_npc, occupancy
    );
endinterface

// File: rtl/if_id_pipe.sv
// -----------------------------------------------------------------------------
// if_id_pipe
//   IF/ID pipeline register with valid/ready handshake, synchronous flush and a
//   2-entry skid buffer. The main register drives decode; the skid register
//   catches the one word fetch may still push in the cycle decode stalls, so
//   in_ready can be a flop rather than a combinational function of out_ready.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of if_id_pipe_if (flush, in_* handshake, out_* handshake,
//           occupancy)
// -----------------------------------------------------------------------------
module if_id_pipe #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013)
) (
    input  logic        clk,
    input  logic        reset,
    if_id_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_main_npc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_npc;

    logic w_out_valid;
    logic w_acc;
    logic w_pop;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_acc       = bus.in_valid & r_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // Data-path steering; writes in a flush cycle are harmless because the
    // state goes EMPTY and the valid bit masks whatever was loaded.
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: w_load_main_in   = w_acc;
            S_ONE: begin
                w_load_main_in   = w_acc & w_pop;
                w_load_skid      = w_acc & ~w_pop;
            end
            S_FULL:  w_load_main_skid = w_pop;
            default: ;
        endcase
    end

    // Occupancy FSM; in_ready is registered as (next state != FULL).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else if (bus.flush) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) r_state <= S_ONE;
                    r_in_ready <= 1'b1;
                end
                S_ONE: begin
                    if (w_acc && !w_pop) begin
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b0;
                    end else begin
                        if (!w_acc && w_pop) r_state <= S_EMPTY;
                        r_in_ready <= 1'b1;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so no accept can coincide
                    if (w_pop) begin
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Data registers carry no reset; only the valid state is reset.
    always_ff @(posedge clk) begin
        if (w_load_main_in) begin
            r_main_instr <= bus.in_instr;
            r_main_npc   <= bus.in_npc;
        end else if (w_load_main_skid) begin
            r_main_instr <= r_skid_instr;
            r_main_npc   <= r_skid_npc;
        end
        if (w_load_skid) begin
            r_skid_instr <= bus.in_instr;
            r_skid_npc   <= bus.in_npc;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = w_out_valid ? r_main_instr : NOP_INSTR;
    assign bus.out_npc   = w_out_valid ? r_main_npc   : '0;
    assign bus.occupancy = r_state;

endmodule
